// File: rtl/rocket_pkg.sv
// rtl/rocket_pkg.sv - shared slot state type, screen bounds and clamp helper for the rocket launcher
package rocket_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LAUNCH = 2'd1,
        FLYING = 2'd2
    } slot_state_t;

    localparam logic signed [11:0] X_MIN = 12'sd0;
    localparam logic signed [11:0] X_MAX = 12'sd639;
    localparam logic signed [11:0] Y_MIN = 12'sd1;
    localparam logic signed [11:0] Y_MAX = 12'sd468;

    localparam int FIXED_POINT_MULTIPLIER = 64;

    function automatic logic signed [10:0] clamp_coord(
        input logic signed [11:0] value,
        input logic signed [11:0] lo,
        input logic signed [11:0] hi
    );
        logic signed [11:0] result;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end else begin
            result = value;
        end
        return result[10:0];
    endfunction

endpackage

// File: rtl/rocket_slot.sv
// rtl/rocket_slot.sv - one rocket slot: FREE/LAUNCH/FLYING state, launch blanking and spawn registers
module rocket_slot
    import rocket_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               launch,
    input  logic signed [10:0] spawnX,
    input  logic signed [10:0] spawnY,
    input  logic signed [10:0] spawnSpeed,
    input  logic               retire,
    output logic               isActive,
    output logic               isFree,
    output logic signed [10:0] initialX,
    output logic signed [10:0] initialY,
    output logic signed [10:0] initialSpeed
);

    slot_state_t state;
    logic        blank_done;

    // Retire is ignored for two cycles after launch: the controller still reports its previous flight.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= FREE;
            blank_done   <= 1'b0;
            initialX     <= '0;
            initialY     <= '0;
            initialSpeed <= '0;
        end else begin
            case (state)
                FREE: begin
                    if (launch) begin
                        state        <= LAUNCH;
                        blank_done   <= 1'b0;
                        initialX     <= spawnX;
                        initialY     <= spawnY;
                        initialSpeed <= spawnSpeed;
                    end
                end
                LAUNCH: begin
                    if (blank_done) begin
                        state <= FLYING;
                    end else begin
                        blank_done <= 1'b1;
                    end
                end
                FLYING: begin
                    if (retire) begin
                        state <= FREE;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

    assign isActive = (state != FREE);
    assign isFree   = (state == FREE);

endmodule

// File: rtl/rocket_launcher.sv
// rtl/rocket_launcher.sv - fire edge detection, slot allocation, spawn clamping and frame cooldown
module rocket_launcher
    import rocket_pkg::*;
#(
    parameter int NUM_ROCKETS     = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ROCKET_SPEED    = -256,
    parameter int X_OFFSET        = 14,
    parameter int Y_OFFSET        = -16
)(
    input  logic                               clk,
    input  logic                               resetN,
    input  logic                               startOfFrame,
    input  logic                               fireRequest,
    input  logic signed [10:0]                 shooterTopLeftX,
    input  logic signed [10:0]                 shooterTopLeftY,
    input  logic [NUM_ROCKETS-1:0]             rocketReachedBorder,
    input  logic [NUM_ROCKETS-1:0]             rocketHit,
    output logic [NUM_ROCKETS-1:0]             isActive,
    output logic [NUM_ROCKETS-1:0][10:0]       initialX,
    output logic [NUM_ROCKETS-1:0][10:0]       initialY,
    output logic [NUM_ROCKETS-1:0][10:0]       initialSpeed,
    output logic                               launchPulse,
    output logic                               launchDenied,
    output logic [$clog2(NUM_ROCKETS+1)-1:0]   activeCount
);

    localparam int CNT_W = $clog2(NUM_ROCKETS + 1);

    localparam logic signed [11:0] X_OFF_W       = 12'(X_OFFSET);
    localparam logic signed [11:0] Y_OFF_W       = 12'(Y_OFFSET);
    localparam logic signed [10:0] SPEED_W       = 11'(ROCKET_SPEED);
    localparam logic [7:0]         COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);

    logic                    fire_d;
    logic                    fire_edge;
    logic                    launch_accept;
    logic [7:0]              cooldown_cnt;
    logic [NUM_ROCKETS-1:0]  slot_free;
    logic [NUM_ROCKETS-1:0]  launch_sel;
    logic signed [11:0]      spawn_x_wide;
    logic signed [11:0]      spawn_y_wide;
    logic signed [10:0]      spawn_x;
    logic signed [10:0]      spawn_y;

    assign fire_edge     = fireRequest & ~fire_d;
    assign launch_accept = fire_edge && (cooldown_cnt == 8'd0) && (|slot_free);

    assign spawn_x_wide = $signed({shooterTopLeftX[10], shooterTopLeftX}) + X_OFF_W;
    assign spawn_y_wide = $signed({shooterTopLeftY[10], shooterTopLeftY}) + Y_OFF_W;
    assign spawn_x      = clamp_coord(spawn_x_wide, X_MIN, X_MAX);
    assign spawn_y      = clamp_coord(spawn_y_wide, Y_MIN, Y_MAX);

    // Lowest-index free slot wins; free flags come from registered state, so a slot retiring now is not eligible.
    always_comb begin
        logic found;
        launch_sel = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            if (slot_free[i] && !found) begin
                launch_sel[i] = launch_accept;
                found         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_d       <= 1'b0;
            cooldown_cnt <= 8'd0;
            launchPulse  <= 1'b0;
            launchDenied <= 1'b0;
        end else begin
            fire_d       <= fireRequest;
            launchPulse  <= launch_accept;
            launchDenied <= fire_edge & ~launch_accept;
            if (launch_accept) begin
                cooldown_cnt <= COOLDOWN_LOAD;
            end else if (startOfFrame && (cooldown_cnt != 8'd0)) begin
                cooldown_cnt <= cooldown_cnt - 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_ROCKETS; i++) begin : g_slot
        rocket_slot u_slot (
            .clk          (clk),
            .resetN       (resetN),
            .launch       (launch_sel[i]),
            .spawnX       (spawn_x),
            .spawnY       (spawn_y),
            .spawnSpeed   (SPEED_W),
            .retire       (rocketReachedBorder[i] | rocketHit[i]),
            .isActive     (isActive[i]),
            .isFree       (slot_free[i]),
            .initialX     (initialX[i]),
            .initialY     (initialY[i]),
            .initialSpeed (initialSpeed[i])
        );
    end

    always_comb begin
        activeCount = '0;
        for (int i = 0; i < NUM_ROCKETS; i++) begin
            activeCount = activeCount + CNT_W'(isActive[i]);
        end
    end

endmodule

// File: tb/tb_rocket_launcher.sv
// tb/tb_rocket_launcher.sv - randomized and directed bench for rocket_launcher against a slot-pool model
module tb_rocket_launcher;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);
    localparam int COOL  = 8;
    localparam int SPEED = -256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 resetN;
    logic                 startOfFrame;
    logic                 fireRequest;
    logic signed [10:0]   shooterTopLeftX;
    logic signed [10:0]   shooterTopLeftY;
    logic [N-1:0]         rocketReachedBorder;
    logic [N-1:0]         rocketHit;
    logic [N-1:0]         isActive;
    logic [N-1:0][10:0]   initialX;
    logic [N-1:0][10:0]   initialY;
    logic [N-1:0][10:0]   initialSpeed;
    logic                 launchPulse;
    logic                 launchDenied;
    logic [CW-1:0]        activeCount;

    rocket_launcher #(
        .NUM_ROCKETS     (N),
        .COOLDOWN_FRAMES (COOL),
        .ROCKET_SPEED    (SPEED),
        .X_OFFSET        (14),
        .Y_OFFSET        (-16)
    ) dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .fireRequest         (fireRequest),
        .shooterTopLeftX     (shooterTopLeftX),
        .shooterTopLeftY     (shooterTopLeftY),
        .rocketReachedBorder (rocketReachedBorder),
        .rocketHit           (rocketHit),
        .isActive            (isActive),
        .initialX            (initialX),
        .initialY            (initialY),
        .initialSpeed        (initialSpeed),
        .launchPulse         (launchPulse),
        .launchDenied        (launchDenied),
        .activeCount         (activeCount)
    );

    int checks   = 0;
    int failures = 0;

    // Model: each slot is "in flight for age cycles"; it may retire once age reaches 2.
    bit m_act [N];
    int m_age [N];
    int m_x   [N];
    int m_y   [N];
    int m_spd [N];
    int m_cd;
    bit m_prev;
    bit m_pulse;
    bit m_denied;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_age[i] = 0; m_x[i] = 0; m_y[i] = 0; m_spd[i] = 0;
        end
        m_cd = 0; m_prev = 0; m_pulse = 0; m_denied = 0;
    endtask

    task automatic model_step();
        bit fe;
        int pick;
        fe     = fireRequest && !m_prev;
        m_prev = fireRequest;
        pick   = -1;
        for (int i = 0; i < N; i++) if (!m_act[i] && pick < 0) pick = i;
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (m_age[i] >= 2 && (rocketReachedBorder[i] || rocketHit[i])) m_act[i] = 0;
                else m_age[i]++;
            end
        end
        m_pulse  = 0;
        m_denied = 0;
        if (fe && m_cd == 0 && pick >= 0) begin
            m_act[pick] = 1;
            m_age[pick] = 0;
            m_x[pick]   = clampi(int'(shooterTopLeftX) + 14, 0, 639);
            m_y[pick]   = clampi(int'(shooterTopLeftY) - 16, 1, 468);
            m_spd[pick] = SPEED;
            m_pulse     = 1;
            m_cd        = COOL;
        end else begin
            if (fe) m_denied = 1;
            if (startOfFrame && m_cd > 0) m_cd--;
        end
    endtask

    task automatic compare_all();
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            cnt += m_act[i];
            check_eq($sformatf("is_active[%0d]", i), isActive[i], m_act[i]);
            check_eq($sformatf("initial_x[%0d]", i), $signed(initialX[i]), m_x[i]);
            check_eq($sformatf("initial_y[%0d]", i), $signed(initialY[i]), m_y[i]);
            check_eq($sformatf("initial_speed[%0d]", i), $signed(initialSpeed[i]), m_spd[i]);
        end
        check_eq("active_count", activeCount, cnt);
        check_eq("launch_pulse", launchPulse, m_pulse);
        check_eq("launch_denied", launchDenied, m_denied);
    endtask

    task automatic cycle(input bit fire, input bit sof, input logic [N-1:0] brd, input logic [N-1:0] hit);
        fireRequest         = fire;
        startOfFrame        = sof;
        rocketReachedBorder = brd;
        rocketHit           = hit;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic frames(input int k);
        for (int f = 0; f < k; f++) begin
            cycle(0, 1, '0, '0);
            cycle(0, 0, '0, '0);
        end
    endtask

    // Reset is asserted between edges, so the slots must clear without a clock edge.
    task automatic do_reset();
        fireRequest = 0; startOfFrame = 0; rocketReachedBorder = '0; rocketHit = '0;
        resetN = 0;
        #1;
        check_eq("reset_is_active", isActive, 0);
        check_eq("reset_active_count", activeCount, 0);
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        resetN = 1;
    endtask

    initial begin
        resetN = 1;
        shooterTopLeftX = 11'sd300;
        shooterTopLeftY = 11'sd440;
        fireRequest = 0; startOfFrame = 0; rocketReachedBorder = '0; rocketHit = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        cycle(1, 0, '0, '0);
        check_eq("first_active", isActive, 4'b0001);
        check_eq("first_x", $signed(initialX[0]), 314);
        check_eq("first_y", $signed(initialY[0]), 424);
        check_eq("first_speed", $signed(initialSpeed[0]), -256);
        check_eq("first_pulse", launchPulse, 1);
        cycle(0, 0, '0, '0);
        frames(3);
        cycle(1, 0, '0, '0);
        check_eq("cooldown_denied", launchDenied, 1);
        check_eq("cooldown_active", isActive, 4'b0001);
        frames(5);
        cycle(1, 0, '0, '0);
        check_eq("slot1_launch", isActive, 4'b0011);

        frames(8);
        cycle(1, 0, '0, '0);
        frames(8);
        cycle(1, 0, '0, '0);
        frames(8);
        cycle(1, 0, '0, '0);
        check_eq("full_denied", launchDenied, 1);
        cycle(0, 0, '0, 4'b0100);
        check_eq("hit2_active", isActive, 4'b1011);
        check_eq("hit2_count", activeCount, 3);
        cycle(1, 0, '0, '0);
        check_eq("slot2_relaunch", isActive, 4'b1111);

        do_reset();
        cycle(1, 0, 4'b0001, '0);
        cycle(0, 0, 4'b0001, '0);
        cycle(0, 0, 4'b0001, '0);
        check_eq("border_blanked", isActive[0], 1);
        cycle(0, 0, 4'b0001, '0);
        check_eq("border_retire", isActive[0], 0);
        cycle(0, 0, '0, '0);

        do_reset();
        shooterTopLeftX = -11'sd20;
        shooterTopLeftY = 11'sd5;
        cycle(1, 0, '0, '0);
        check_eq("clamp_x", $signed(initialX[0]), 0);
        check_eq("clamp_y", $signed(initialY[0]), 1);
        for (int s = 0; s < 3; s++) begin
            frames(8);
            cycle(1, 0, '0, '0);
        end
        frames(8);
        cycle(1, 0, '0, 4'b0010);
        check_eq("retire_fire_denied", launchDenied, 1);
        check_eq("retire_fire_gap", isActive[1], 0);
        cycle(0, 0, '0, '0);
        cycle(1, 0, '0, '0);
        check_eq("reuse_launch", isActive, 4'b1111);
        check_eq("reuse_pulse", launchPulse, 1);

        do_reset();
        shooterTopLeftX = 11'sd100;
        shooterTopLeftY = 11'sd200;
        for (int s = 0; s < 3; s++) begin
            cycle(1, 0, '0, '0);
            frames(8);
        end
        check_eq("three_flying", isActive, 4'b0111);
        do_reset();
        cycle(1, 0, '0, '0);
        check_eq("post_reset_cooldown_zero", launchPulse, 1);

        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] b;
            logic [N-1:0] h;
            b = '0;
            h = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) b[i] = 1'b1;
                if ($urandom_range(0, 15) == 0) h[i] = 1'b1;
            end
            shooterTopLeftX = 11'($urandom_range(0, 2047));
            shooterTopLeftY = 11'($urandom_range(0, 2047));
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, b, h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
